// File: rtl/fft_pkg.sv
// fft_pkg: shared defaults, complex point type and helpers for the streaming fft adapter.
package fft_pkg;

    localparam int FFT_DATA_W     = 16;
    localparam int FFT_N_POINTS   = 8;
    localparam int FFT_CORE_LAT   = 4;
    localparam int FFT_FIFO_DEPTH = 4;

    typedef struct packed {
        logic signed [FFT_DATA_W-1:0] r;
        logic signed [FFT_DATA_W-1:0] i;
    } complex_t;

    // Pointer width with one wrap bit, so full and empty are distinguishable.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Negate a w-bit value carried in 32 bits; the most negative code saturates to max positive.
    function automatic logic signed [31:0] conj_sat(input logic signed [31:0] v, input int w);
        logic signed [31:0] lo;
        lo = -(32'sd1 <<< (w - 1));
        return (v == lo) ? ~lo : -v;
    endfunction

endpackage

// File: rtl/fft_frame_fifo.sv
// fft_frame_fifo: first-word-fall-through FIFO; head entry is visible whenever valid is high.
module fft_frame_fifo
    import fft_pkg::*;
#(
    parameter int W     = 1,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic         valid,
    output logic [W-1:0] dout
);

    localparam int PW = ptr_w(DEPTH);
    localparam int AW = PW - 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr, rd;

    assign valid = wr != rd;
    assign dout  = mem[rd[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr <= '0;
            rd <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr[AW-1:0]] <= din;
                wr <= wr + PW'(1);
            end
            if (pop && valid) rd <= rd + PW'(1);
        end
    end

endmodule

// File: rtl/fft_stream_adapter.sv
// fft_stream_adapter: valid/ready wrapper around a next/next_out dft core, forward and inverse via conjugation.
// Define FFT_IFFT_SCALE_EN to scale inverse results by 1/N_POINTS with half-up rounding.
module fft_stream_adapter
    import fft_pkg::*;
#(
    parameter int N_POINTS   = FFT_N_POINTS,
    parameter int DATA_W     = FFT_DATA_W,
    parameter int CORE_LAT   = FFT_CORE_LAT,
    parameter int FIFO_DEPTH = FFT_FIFO_DEPTH
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         in_inverse,
    input  logic [N_POINTS*2*DATA_W-1:0] in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         out_inverse,
    output logic [N_POINTS*2*DATA_W-1:0] out_data,
    output logic                         core_next,
    output logic [N_POINTS*2*DATA_W-1:0] core_x,
    input  logic                         core_next_out,
    input  logic [N_POINTS*2*DATA_W-1:0] core_y,
    output logic                         err_spurious
);

    localparam int FW = N_POINTS * 2 * DATA_W;
    localparam int CW = ptr_w(FIFO_DEPTH);

    if (N_POINTS < 4 || N_POINTS > 64 || (N_POINTS & (N_POINTS - 1)) != 0 ||
        FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || CORE_LAT < 1) begin : g_bad_cfg
        $error("fft_stream_adapter: unsupported parameter set");
    end

    logic          accept, pop, tag_valid, tag_out, tag_q, cap_q;
    logic [FW-1:0] conj_in, x_q, cap_frame;
    logic [FW:0]   out_word;
    logic [CW-1:0] credits, credits_n;

    assign accept    = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign credits_n = credits + CW'(accept) - CW'(pop);

    assign out_inverse = out_word[FW];
    assign out_data    = out_word[FW-1:0];

`ifdef FFT_IFFT_SCALE_EN
    localparam int S = $clog2(N_POINTS);
    localparam logic signed [DATA_W:0] HALF = (DATA_W + 1)'(1 << (S - 1));
`endif

    for (genvar k = 0; k < N_POINTS; k++) begin : g_pt
        localparam int RE = 2 * k * DATA_W;
        localparam int IM = (2 * k + 1) * DATA_W;
        logic signed [DATA_W-1:0] in_im, y_re, y_im, y_ci;
        assign in_im = in_data[IM +: DATA_W];
        assign y_re  = core_y[RE +: DATA_W];
        assign y_im  = core_y[IM +: DATA_W];
        assign y_ci  = tag_q ? DATA_W'(conj_sat(32'(y_im), DATA_W)) : y_im;
        assign conj_in[RE +: DATA_W] = in_data[RE +: DATA_W];
        assign conj_in[IM +: DATA_W] = in_inverse ? DATA_W'(conj_sat(32'(in_im), DATA_W)) : in_im;
`ifdef FFT_IFFT_SCALE_EN
        assign cap_frame[RE +: DATA_W] = tag_q ? DATA_W'(((DATA_W + 1)'(y_re) + HALF) >>> S) : y_re;
        assign cap_frame[IM +: DATA_W] = tag_q ? DATA_W'(((DATA_W + 1)'(y_ci) + HALF) >>> S) : y_ci;
`else
        assign cap_frame[RE +: DATA_W] = y_re;
        assign cap_frame[IM +: DATA_W] = y_ci;
`endif
    end

    // in_ready is registered from the next credit count, so out_ready never reaches it combinationally.
    always_ff @(posedge clk) begin
        if (reset) begin
            credits      <= '0;
            in_ready     <= 1'b0;
            core_next    <= 1'b0;
            core_x       <= '0;
            x_q          <= '0;
            cap_q        <= 1'b0;
            tag_q        <= 1'b0;
            err_spurious <= 1'b0;
        end else begin
            credits      <= credits_n;
            in_ready     <= credits_n < CW'(FIFO_DEPTH);
            core_next    <= accept;
            if (accept) x_q <= conj_in;
            if (core_next) core_x <= x_q;
            cap_q        <= core_next_out & tag_valid;
            if (core_next_out & tag_valid) tag_q <= tag_out;
            err_spurious <= err_spurious | (core_next_out & ~tag_valid);
        end
    end

    fft_frame_fifo #(.W(1), .DEPTH(FIFO_DEPTH)) u_tag_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (accept),
        .din   (in_inverse),
        .pop   (core_next_out),
        .valid (tag_valid),
        .dout  (tag_out)
    );

    fft_frame_fifo #(.W(FW + 1), .DEPTH(FIFO_DEPTH)) u_out_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (cap_q),
        .din   ({tag_q, cap_frame}),
        .pop   (out_ready),
        .valid (out_valid),
        .dout  (out_word)
    );

endmodule

// File: tb/tb_fft_stream_adapter.sv
// tb_fft_stream_adapter: directed bench with a behavioural dft core and a frame-level scoreboard.
module tb_fft_stream_adapter;
    import fft_pkg::*;

    localparam int N = 8, DW = 16, LAT = 4, DEPTH = 4, FW = N * 2 * DW;

    logic clk = 1'b0, reset = 1'b1;
    logic in_valid = 1'b0, in_inverse = 1'b0, out_ready = 1'b0, core_next_out = 1'b0, spur_req = 1'b0;
    logic [FW-1:0] in_data = '0, core_y = '0;
    logic in_ready, out_valid, out_inverse, core_next, err_spurious;
    logic [FW-1:0] out_data, core_x;
    int checks = 0, errors = 0, cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fft_stream_adapter #(.N_POINTS(N), .DATA_W(DW), .CORE_LAT(LAT), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_inverse(in_inverse),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_inverse(out_inverse),
        .out_data(out_data), .core_next(core_next), .core_x(core_x), .core_next_out(core_next_out),
        .core_y(core_y), .err_spurious(err_spurious)
    );

    task automatic check(input string name, input logic [FW:0] act, input logic [FW:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int rnd(input real v);
        return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
    endfunction

    function automatic int sat_neg(input int v);
        return (v == -(1 << (DW - 1))) ? (1 << (DW - 1)) - 1 : -v;
    endfunction

    // Plain DFT, X[k] = sum x[n] e^{-j 2 pi n k / N}, rounded to nearest.
    function automatic logic [FW-1:0] dft(input logic [FW-1:0] x);
        logic [FW-1:0] y;
        real ar, ai, th;
        int xr, xi;
        y = '0;
        for (int k = 0; k < N; k++) begin
            ar = 0.0;
            ai = 0.0;
            for (int n = 0; n < N; n++) begin
                xr = int'($signed(x[2*n*DW +: DW]));
                xi = int'($signed(x[(2*n+1)*DW +: DW]));
                th = 6.283185307179586 * real'(n * k) / real'(N);
                ar = ar + xr * $cos(th) + xi * $sin(th);
                ai = ai + xi * $cos(th) - xr * $sin(th);
            end
            y[2*k*DW +: DW]     = DW'(rnd(ar));
            y[(2*k+1)*DW +: DW] = DW'(rnd(ai));
        end
        return y;
    endfunction

    // Expected output frame {tag, data}: inverse = conj(DFT(conj x)), optionally scaled by 1/N.
    function automatic logic [FW:0] model(input logic [FW-1:0] x, input logic inv);
        logic [FW-1:0] c, y;
        int vr, vi;
        c = x;
        if (inv) for (int n = 0; n < N; n++)
            c[(2*n+1)*DW +: DW] = DW'(sat_neg(int'($signed(x[(2*n+1)*DW +: DW]))));
        y = dft(c);
        if (inv) for (int k = 0; k < N; k++) begin
            vr = int'($signed(y[2*k*DW +: DW]));
            vi = sat_neg(int'($signed(y[(2*k+1)*DW +: DW])));
`ifdef FFT_IFFT_SCALE_EN
            vr = (vr + N / 2) >>> $clog2(N);
            vi = (vi + N / 2) >>> $clog2(N);
`endif
            y[2*k*DW +: DW]     = DW'(vr);
            y[(2*k+1)*DW +: DW] = DW'(vi);
        end
        return {inv, y};
    endfunction

    // Behavioural core: next at cycle c, x sampled at c+1, next_out at c+LAT, y valid at c+LAT+1.
    typedef struct { int due; logic [FW-1:0] y; } job_t;
    job_t jobs[$];
    logic prev_next = 1'b0;
    initial forever begin
        @(negedge clk);
        if (reset) begin
            jobs.delete();
            prev_next = 1'b0;
            core_next_out = 1'b0;
            core_y = '0;
        end else begin
            if (prev_next) jobs.push_back('{cyc - 1 + LAT, dft(core_x)});
            prev_next = core_next;
            if (jobs.size() > 0 && jobs[0].due == cyc - 1) begin
                core_y = jobs[0].y;
                jobs.pop_front();
            end
            core_next_out = spur_req || (jobs.size() > 0 && jobs[0].due == cyc);
        end
    end

    // Scoreboard and output compare, every cycle.
    logic [FW:0] exp_q[$];
    logic [FW:0] prev_word = '0;
    logic prev_hold = 1'b0;
    initial forever begin
        @(negedge clk);
        if (reset) begin
            exp_q.delete();
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                check("hold_valid", out_valid, 1);
                check("hold_data", {out_inverse, out_data}, prev_word);
            end
            if (in_valid && in_ready) exp_q.push_back(model(in_data, in_inverse));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check("unexpected_frame", {out_inverse, out_data}, 'x);
                else begin
                    check("frame", {out_inverse, out_data}, exp_q[0]);
                    void'(exp_q.pop_front());
                end
            end
            prev_hold = out_valid && !out_ready;
            prev_word = {out_inverse, out_data};
        end
    end

    // Called at posedge+1; returns at posedge+1 of the cycle after acceptance.
    task automatic send(input logic [FW-1:0] d, input logic inv, output int t);
        in_valid = 1'b1;
        in_data = d;
        in_inverse = inv;
        t = -1;
        for (int i = 0; i < 50 && t < 0; i++) begin
            @(negedge clk);
            if (in_ready) t = cyc;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (t < 0) check("send_timeout", 0, 1);
    endtask

    // Returns at the negedge of the first cycle with out_valid.
    task automatic wait_out(output int c);
        c = -1;
        for (int i = 0; i < 40 && c < 0; i++) begin
            @(negedge clk);
            if (out_valid) c = cyc;
            else begin
                @(posedge clk);
                #1;
            end
        end
        if (c < 0) check("out_timeout", 0, 1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, c, acc, bad_v, bad_e;
        logic [FW-1:0] d, e;
        logic [FW-1:0] f[6];

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_inverse", out_inverse, 0);
        check("rst_out_data", out_data, 0);
        check("rst_core_next", core_next, 0);
        check("rst_core_x", core_x, 0);
        check("rst_err", err_spurious, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        out_ready = 1'b1;
        idle(1);
        @(negedge clk);
        check("in_ready_after_reset", in_ready, 1);
        @(posedge clk);
        #1;

        // Forward impulse: flat spectrum, latency 7.
        d = '0;
        d[15:0] = 16'd1000;
        send(d, 1'b0, t);
        wait_out(c);
        check("impulse_latency", c, t + 7);
        check("impulse_data", out_data, {8{16'd0, 16'd1000}});
        check("impulse_tag", out_inverse, 0);
        idle(1);

        // Inverse of a constant: energy only at point 0.
        send({8{16'd0, 16'd800}}, 1'b1, t);
        wait_out(c);
        e = '0;
`ifdef FFT_IFFT_SCALE_EN
        e[15:0] = 16'd800;
`else
        e[15:0] = 16'd6400;
`endif
        check("inverse_data", out_data, e);
        check("inverse_tag", out_inverse, 1);
        idle(1);

        // Saturating conjugation of the most negative imag part.
        d = '0;
        d[3*32+16 +: 16] = 16'h8000;
        send(d, 1'b1, t);
        @(negedge clk);
        check("core_next_pulse", core_next, 1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("sat_core_x", core_x[3*32+16 +: 16], 16'h7fff);
        idle(12);

        // Mixed back-to-back frames, checked by the scoreboard.
        for (int j = 0; j < 4; j++) begin
            for (int p = 0; p < 2 * N; p++) d[p*DW +: DW] = DW'(int'($urandom_range(4000)) - 2000);
            send(d, logic'(j % 2), t);
        end
        idle(16);
        check("drain_mixed", exp_q.size(), 0);

        // Backpressure: four credits, then stall.
        out_ready = 1'b0;
        for (int j = 0; j < 6; j++)
            for (int p = 0; p < 2 * N; p++) f[j][p*DW +: DW] = DW'(int'($urandom_range(2000)) - 1000);
        acc = 0;
        for (int i = 0; i < 12; i++) begin
            in_valid = 1'b1;
            in_data = f[acc < 6 ? acc : 5];
            in_inverse = logic'(acc % 2);
            @(negedge clk);
            if (in_ready) acc++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check("bp_accepted", acc, 4);
        idle(14);
        @(negedge clk);
        check("bp_in_ready_low", in_ready, 0);
        check("bp_out_valid", out_valid, 1);
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        check("bp_first_pop_ready", in_ready, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("bp_ready_returns", in_ready, 1);
        idle(6);
        check("drain_bp", exp_q.size(), 0);

        // Spurious core pulse with nothing in flight.
        spur_req = 1'b1;
        idle(1);
        spur_req = 1'b0;
        bad_v = 0;
        bad_e = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) bad_v++;
            if (i > 0 && !err_spurious) bad_e++;
        end
        check("spur_no_output", bad_v, 0);
        check("spur_err_sticky", bad_e, 0);
        idle(1);

        // Reset with one frame buffered and two in flight.
        out_ready = 1'b0;
        send({8{16'd0, 16'd300}}, 1'b0, t);
        wait_out(c);
        idle(1);
        send({8{16'd5, 16'd100}}, 1'b1, t);
        send({8{16'd7, 16'd200}}, 1'b0, t);
        reset = 1'b1;
        idle(1);
        @(negedge clk);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_in_ready", in_ready, 0);
        check("mid_rst_err", err_spurious, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        out_ready = 1'b1;
        idle(1);
        @(negedge clk);
        check("post_rst_in_ready", in_ready, 1);
        bad_v = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) bad_v++;
        end
        check("post_rst_no_stale", bad_v, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fft_stream_adapter.md
Name: fft_stream_adapter

Overview:
- Parametrised successor to the fixed-size fft/ifft wrappers: adds a valid/ready streaming front end around any N-point, fully parallel dft core that uses the next/next_out pulse protocol.
- Runs forward and inverse transforms through one forward core by conjugating input and output, selected per frame.
- Buffers results in a frame FIFO so downstream backpressure never stalls the non-stallable core.
- Sits between the convolution-layer tile loader and the pointwise-multiply stage.

Parameters:
- N_POINTS, 8, transform size; power of two, 4..64.
- DATA_W, 16, signed width of each real/imag component.
- CORE_LAT, 4, cycles from the core_next cycle to the core_next_out cycle; matches the attached core.
- FIFO_DEPTH, 4, output frame FIFO depth in frames; power of two, >= 2.

Ports:
- clk in 1: clock.
- reset in 1: synchronous, active-high; also drives the core reset externally.
- in_valid in 1: input frame valid.
- in_ready out 1: adapter accepts the frame this cycle.
- in_inverse in 1: 1 = inverse transform for this frame.
- in_data in N_POINTS*2*DATA_W: point k imag at [(2k+1)*DATA_W +: DATA_W], real at [2k*DATA_W +: DATA_W].
- out_valid out 1: output frame valid.
- out_ready in 1: downstream accepts the frame.
- out_inverse out 1: mode tag of the output frame.
- out_data out N_POINTS*2*DATA_W: result frame, same packing as in_data.
- core_next out 1: start pulse to the core.
- core_x out N_POINTS*2*DATA_W: core input, valid the cycle after core_next.
- core_next_out in 1: core pulse; core_y is valid the following cycle.
- core_y in N_POINTS*2*DATA_W: core output.
- err_spurious out 1: sticky; core_next_out seen with no frame in flight.

Behaviour:
- Reset values: in_ready=0, out_valid=0, out_inverse=0, out_data=0, core_next=0, core_x=0, err_spurious=0. in_ready goes high the first cycle after reset deasserts.
- Credit counter: credits = in-flight frames + FIFO occupancy, range 0..FIFO_DEPTH.
  - in_ready = (credits < FIFO_DEPTH), computed from registered state only; no combinational path from out_ready.
  - Increment on accept (in_valid & in_ready); decrement on output pop (out_valid & out_ready).
  - Simultaneous accept and pop leaves the count unchanged.
- Input stage:
  - Cycle t, accept: register the frame. If in_inverse=1, negate every imag part; -2^(DATA_W-1) saturates to 2^(DATA_W-1)-1.
  - Cycle t+1: core_next=1.
  - Cycle t+2: core_x = registered frame.
  - Back-to-back accepts give core_next every cycle; core_x holds its last value when idle.
- Tag FIFO: depth FIFO_DEPTH, holds the in_inverse bit per in-flight frame; push on accept, pop on core_next_out.
- Capture:
  - Cycle after core_next_out: push core_y, plus the popped tag, into the output FIFO.
  - For inverse frames, negate imag with the same saturation rule before the push.
  - Output FIFO cannot overflow: guaranteed by credits.
- Latency: accept at t; out_valid at t+CORE_LAT+3 when the FIFO is empty and out_ready=1.
- Output: FWFT. out_data/out_inverse are stable while out_valid & !out_ready; wrap-around uses log2(FIFO_DEPTH)+1 pointers.
- Spurious core_next_out (tag FIFO empty): ignored, no push, err_spurious set until reset.
- Reset mid-operation: all in-flight and buffered frames are discarded, credits=0. Core outputs arriving after reset are ignored; since the core is reset too, none are expected.

Optional Feature:
- FFT_IFFT_SCALE_EN defined: inverse frames have both components arithmetically shifted right by log2(N_POINTS), rounded half-up (add 2^(s-1) before shifting), after conjugation and before the FIFO push. This gives a true 1/N inverse.
- Not defined: no scaling; inverse output is N times the true value. Forward frames are never scaled.

Decomposition:
- Package fft_pkg:
  - complex_t struct {r, i} with signed DATA_W fields, using package constant FFT_DATA_W=16 as the default.
  - conj_sat function.
  - clog2-based localparams for pointer and credit widths.
- One sub-module: fft_frame_fifo (parametrised width/depth FWFT FIFO), instantiated twice: tag FIFO (width 1) and output FIFO.

Test Plan:
- Single forward frame: impulse (1000+j0 at point 0, zeros elsewhere), N=8, CORE_LAT=4 behavioural core model -> out_valid at t+7; all 8 points = 1000+j0; out_inverse=0.
- Inverse with FFT_IFFT_SCALE_EN: 8 points all 800+j0 -> point 0 = 800+j0, others 0. Without the macro -> point 0 = 6400+j0.
- Saturation: inverse frame with imag = -32768 at point 3 -> core_x point 3 imag = 32767.
- Backpressure: out_ready=0, 6 frames offered back-to-back, FIFO_DEPTH=4 -> exactly 4 accepted, then in_ready=0. Release out_ready -> 4 frames emitted in order, mode tags intact, in_ready returns the cycle after the first pop.
- Spurious pulse: core_next_out with nothing in flight -> no out_valid, err_spurious=1 held.
- Reset mid-stream: reset asserted with 2 frames in flight and 1 buffered -> next cycle out_valid=0, in_ready=0. After release: in_ready=1, no stale frames emitted.
